// File: rtl/n4by4_b2_mul_arbiter.sv
// Two-client arbiter around one shared 4x4 signed sequential multiplier.
//
// Ports:
//   clock              single clock, all state updates on the rising edge
//   reset_             synchronous active-low reset
//   req_a, req_b       client requests (4-phase handshake)
//   xa3_xa0, ya3_ya0   client A signed operands
//   xb3_xb0, yb3_yb0   client B signed operands
//   ack_a, ack_b       client acknowledges; product valid while high
//   p7_p0              registered signed product for the acknowledged client
//   busy               high whenever the FSM is not idle
//
// A granted operation takes one IDLE cycle, four shift-and-add cycles on
// operand magnitudes, and one SIGN cycle that applies the product sign.
module n4by4_b2_mul_arbiter (
    input  logic       clock,
    input  logic       reset_,
    input  logic       req_a,
    input  logic [3:0] xa3_xa0,
    input  logic [3:0] ya3_ya0,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [3:0] xb3_xb0,
    input  logic [3:0] yb3_yb0,
    output logic       ack_b,
    output logic [7:0] p7_p0,
    output logic       busy
);

    typedef enum logic [1:0] {StIdle, StMul, StSign, StAck} state_t;

    state_t     r_state;
    state_t     w_state_d;

    logic       r_grant_b;  // 1: client B owns the multiplier
    logic       r_prio_b;   // 1: B wins the next tie
    logic [3:0] r_mcand;
    logic [3:0] r_mplier;
    logic       r_neg;
    logic [7:0] r_acc;
    logic [1:0] r_cnt;
    logic [7:0] r_p;
    logic       r_ack_a;
    logic       r_ack_b;

    logic       w_any_req;
    logic       w_grant_b;
    logic       w_req_grant;
    logic [3:0] w_sel_x;
    logic [3:0] w_sel_y;
    logic [7:0] w_partial;
    logic [7:0] w_acc_neg;

    // -8 maps to 4'b1000, which is read as unsigned 8.
    function automatic logic [3:0] mag(input logic [3:0] v);
        return v[3] ? (~v + 4'd1) : v;
    endfunction

    assign w_any_req   = req_a | req_b;
    assign w_grant_b   = (req_a & req_b) ? r_prio_b : req_b;
    assign w_req_grant = r_grant_b ? req_b : req_a;
    assign w_sel_x     = w_grant_b ? xb3_xb0 : xa3_xa0;
    assign w_sel_y     = w_grant_b ? yb3_yb0 : ya3_ya0;
    assign w_partial   = r_mplier[r_cnt] ? ({4'b0000, r_mcand} << r_cnt) : 8'h00;
    assign w_acc_neg   = ~r_acc + 8'd1;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: if (w_any_req) w_state_d = StMul;
            StMul:  if (r_cnt == 2'd3) w_state_d = StSign;
            StSign: w_state_d = StAck;
            StAck:  if (!w_req_grant) w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            r_grant_b <= 1'b0;
            r_prio_b  <= 1'b0;
            r_mcand   <= 4'h0;
            r_mplier  <= 4'h0;
            r_neg     <= 1'b0;
            r_acc     <= 8'h00;
            r_cnt     <= 2'd0;
            r_p       <= 8'h00;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_grant_b <= w_grant_b;
                        r_mcand   <= mag(w_sel_x);
                        r_mplier  <= mag(w_sel_y);
                        r_neg     <= w_sel_x[3] ^ w_sel_y[3];
                        r_acc     <= 8'h00;
                        r_cnt     <= 2'd0;
                    end
                end
                StMul: begin
                    r_acc <= r_acc + w_partial;
                    r_cnt <= r_cnt + 2'd1;
                end
                StSign: begin
                    // Negating zero yields zero, so -0 needs no special case.
                    r_p     <= r_neg ? w_acc_neg : r_acc;
                    r_ack_a <= ~r_grant_b;
                    r_ack_b <= r_grant_b;
                end
                StAck: begin
                    if (!w_req_grant) begin
                        r_ack_a  <= 1'b0;
                        r_ack_b  <= 1'b0;
                        r_prio_b <= ~r_grant_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack_a = r_ack_a;
    assign ack_b = r_ack_b;
    assign p7_p0 = r_p;
    assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_n4by4_b2_mul_arbiter.sv
// Directed self-checking bench for n4by4_b2_mul_arbiter.
module tb_n4by4_b2_mul_arbiter;

    logic       clock;
    logic       reset_;
    logic       req_a;
    logic [3:0] xa3_xa0;
    logic [3:0] ya3_ya0;
    logic       ack_a;
    logic       req_b;
    logic [3:0] xb3_xb0;
    logic [3:0] yb3_yb0;
    logic       ack_b;
    logic [7:0] p7_p0;
    logic       busy;

    int checks = 0;
    int errors = 0;

    n4by4_b2_mul_arbiter dut (
        .clock   (clock),
        .reset_  (reset_),
        .req_a   (req_a),
        .xa3_xa0 (xa3_xa0),
        .ya3_ya0 (ya3_ya0),
        .ack_a   (ack_a),
        .req_b   (req_b),
        .xb3_xb0 (xb3_xb0),
        .yb3_yb0 (yb3_yb0),
        .ack_b   (ack_b),
        .p7_p0   (p7_p0),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_ === 1'b1) begin
            checks++;
            assert (!(ack_a === 1'b1 && ack_b === 1'b1)) else begin
                errors++;
                $error("FAIL both_acks: observed ack_a=%b ack_b=%b expected not both 1",
                       ack_a, ack_b);
            end
        end
    end

    // Called right after the edge that sampled the request in IDLE.
    task automatic expect_ack(input bit is_b, input logic [7:0] exp, input string tag);
        repeat (4) tick();
        chk({tag, "_ack_early"}, {7'd0, is_b ? ack_b : ack_a}, 8'h00);
        tick();
        chk({tag, "_ack"}, {7'd0, is_b ? ack_b : ack_a}, 8'h01);
        chk({tag, "_other_ack"}, {7'd0, is_b ? ack_a : ack_b}, 8'h00);
        chk({tag, "_p"}, p7_p0, exp);
    endtask

    // Full transaction; operands are scrambled after grant to show they are ignored.
    task automatic txn(input bit is_b, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] exp, input string tag);
        if (is_b) begin
            xb3_xb0 = x; yb3_yb0 = y; req_b = 1'b1;
        end else begin
            xa3_xa0 = x; ya3_ya0 = y; req_a = 1'b1;
        end
        tick();
        chk({tag, "_busy"}, {7'd0, busy}, 8'h01);
        if (is_b) begin
            xb3_xb0 = ~x; yb3_yb0 = y + 4'd3;
        end else begin
            xa3_xa0 = ~x; ya3_ya0 = y + 4'd3;
        end
        expect_ack(is_b, exp, tag);
        if (is_b) req_b = 1'b0;
        else      req_a = 1'b0;
        tick();
        chk({tag, "_ack_drop"}, {6'd0, ack_a, ack_b}, 8'h00);
        chk({tag, "_idle"}, {7'd0, busy}, 8'h00);
    endtask

    initial begin
        logic [1:0] order;
        reset_ = 1'b0;
        req_a = 1'b0; req_b = 1'b0;
        xa3_xa0 = 4'h0; ya3_ya0 = 4'h0; xb3_xb0 = 4'h0; yb3_yb0 = 4'h0;
        #1;
        tick();
        tick();
        chk("rst_ack_a", {7'd0, ack_a}, 8'h00);
        chk("rst_ack_b", {7'd0, ack_b}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_p", p7_p0, 8'h00);
        reset_ = 1'b1;
        tick();

        txn(1'b0, 4'h3, 4'h5, 8'h0F, "a_3x5");
        txn(1'b0, 4'h8, 4'h8, 8'h40, "a_m8xm8");
        txn(1'b1, 4'h8, 4'h7, 8'hC8, "b_m8x7");
        txn(1'b0, 4'hD, 4'h0, 8'h00, "a_m3x0");
        txn(1'b1, 4'h7, 4'hF, 8'hF9, "b_7xm1");

        // Round-robin with both requests held.
        reset_ = 1'b0;
        tick();
        reset_ = 1'b1;
        xa3_xa0 = 4'h2; ya3_ya0 = 4'h3;
        xb3_xb0 = 4'hE; yb3_yb0 = 4'h3;
        req_a = 1'b1; req_b = 1'b1;
        order = 2'b10;  // bit0: expected grant is B
        for (int n = 0; n < 4; n++) begin
            order[0] = n[0];
            for (int k = 0; k < 12 && !(ack_a || ack_b); k++) tick();
            chk("rr_ack_seen", {7'd0, ack_a | ack_b}, 8'h01);
            chk("rr_grant", {6'd0, ack_a, ack_b}, order[0] ? 8'h01 : 8'h02);
            chk("rr_p", p7_p0, order[0] ? 8'hFA : 8'h06);
            if (order[0]) req_b = 1'b0;
            else          req_a = 1'b0;
            tick();
            chk("rr_ack_drop", {6'd0, ack_a, ack_b}, 8'h00);
            req_a = 1'b1; req_b = 1'b1;
        end
        req_a = 1'b0; req_b = 1'b0;
        repeat (8) tick();
        if (ack_a) req_a = 1'b0;
        repeat (8) tick();
        chk("rr_settle_busy", {7'd0, busy}, 8'h00);

        // Reset during MUL aborts, held request restarts.
        xa3_xa0 = 4'hD; ya3_ya0 = 4'h5;
        req_a = 1'b1;
        tick();
        tick();
        reset_ = 1'b0;
        tick();
        chk("mrst_ack_a", {7'd0, ack_a}, 8'h00);
        chk("mrst_p", p7_p0, 8'h00);
        chk("mrst_busy", {7'd0, busy}, 8'h00);
        reset_ = 1'b1;
        tick();
        expect_ack(1'b0, 8'hF1, "mrst_redo");
        req_a = 1'b0;
        tick();
        chk("mrst_ack_drop", {7'd0, ack_a}, 8'h00);

        // Early request drop during MUL.
        xa3_xa0 = 4'h6; ya3_ya0 = 4'hE;
        req_a = 1'b1;
        tick();
        tick();
        req_a = 1'b0;
        repeat (3) tick();
        chk("early_ack_low", {7'd0, ack_a}, 8'h00);
        tick();
        chk("early_ack", {7'd0, ack_a}, 8'h01);
        chk("early_p", p7_p0, 8'hF4);
        tick();
        chk("early_ack_one", {7'd0, ack_a}, 8'h00);
        chk("early_idle", {7'd0, busy}, 8'h00);
        chk("early_p_hold", p7_p0, 8'hF4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
